// File: rtl/booth_result_serializer.sv
// Buffers wide products from the Booth multiplier and streams each one out
// as WORD_W-bit words, least-significant word first, with valid/ready handshaking.
module booth_result_serializer #(
    parameter int PROD_W = 448,
    parameter int WORD_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PROD_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WORD_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int N     = PROD_W / WORD_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef logic [N-1:0][WORD_W-1:0] prod_t;
    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    prod_t             mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [IDX_W-1:0]  word_idx;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_next;
    logic              overflow_q;
    logic              push;
    logic              pop;
    logic              xfer;
    logic              at_last;

    // in_ready depends only on the registered fill level, never on out_ready.
    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (state == SEND);
    assign at_last   = (word_idx == IDX_W'(N - 1));
    assign out_last  = out_valid && at_last;
    assign xfer      = out_valid && out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = xfer && at_last;
    assign out_data  = out_valid ? mem[rd_ptr][word_idx] : '0;
    assign level     = level_q;
    assign overflow  = overflow_q;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        level_next = level_q;
        case ({push, pop})
            2'b10:   level_next = level_q + 1'b1;
            2'b01:   level_next = level_q - 1'b1;
            default: level_next = level_q;
        endcase
    end

    // NOTE: the product storage has no reset; pointers and level decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_idx   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q <= level_next;
            state   <= (level_next != '0) ? SEND : IDLE;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (in_valid && !in_ready) begin
                overflow_q <= 1'b1;
            end

            if (xfer) begin
                if (at_last) begin
                    word_idx <= '0;
                    rd_ptr   <= rd_ptr + 1'b1;
                end else begin
                    word_idx <= word_idx + 1'b1;
                end
            end
        end
    end

endmodule
